tron_score_tracker: RTL and testbench

- Match-level score keeper for the Tron game. Generalises the two-player score counter to N players with a configurable score width.
- Adds a round-accept handshake, draw handling, first-to-WIN_SCORE match detection and a round counter.
- Sits between game-over detection logic (round result producer) and the HEX/VGA score display.

---
 rtl/tron_score_pkg.sv | 29 ++
 rtl/tron_score_tracker_if.sv | 28 ++
 rtl/tron_score_tracker_score_counter.sv | 37 +++
 rtl/tron_score_tracker.sv | 156 +++++++++++++++
 tb/tb_tron_score_tracker.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tron_score_pkg.sv
// Shared definitions for the Tron match score tracker.
//   state_t    : tracker FSM states (IDLE, CHECK, MATCH_END)
//   clog2_min1 : id field width for a player count, never below 1 bit
//   params_ok  : legality of a parameter set (2..8 players, WIN_SCORE
//                representable in SCORE_W+1 bits)
package tron_score_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        MATCH_END = 2'd2
    } state_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit params_ok(input int num_players, input int score_w,
                                     input int win_score);
        bit ok;
        ok = (num_players >= 2) && (num_players <= 8) && (score_w >= 1);
        if (score_w < 30)
            ok = ok && (win_score >= 0) && (win_score < (1 << (score_w + 1)));
        return ok;
    endfunction

endpackage

// File: rtl/tron_score_tracker_if.sv
// Round result handshake between the game-over detector (master) and the
// score tracker (slave).
//   round_over  : one-cycle result strobe, taken only while round_ready=1
//   round_draw  : with round_over, the round was drawn
//   winner_id   : with round_over, index of the winning player
//   round_ready : tracker can accept a result this cycle
interface tron_score_tracker_if #(
    parameter int ID_W = 1
);
    logic            round_over;
    logic            round_draw;
    logic [ID_W-1:0] winner_id;
    logic            round_ready;

    modport master (
        output round_over,
        output round_draw,
        output winner_id,
        input  round_ready
    );

    modport slave (
        input  round_over,
        input  round_draw,
        input  winner_id,
        output round_ready
    );
endinterface

// File: rtl/tron_score_tracker_score_counter.sv
// Single player score counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear to zero (wins over inc)
//   inc          : add one point
//   value        : current score
// Overflow wraps modulo 2^SCORE_W by default; with TRON_SCORE_SATURATE_EN
// defined the score holds at its maximum.
module score_counter #(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] value
);

    logic [SCORE_W-1:0] value_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_reg <= '0;
        end else if (clear) begin
            value_reg <= '0;
        end else if (inc) begin
`ifdef TRON_SCORE_SATURATE_EN
            if (value_reg != '1)
                value_reg <= value_reg + 1'b1;
`else
            value_reg <= value_reg + 1'b1;
`endif
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/tron_score_tracker.sv
// Match-level score keeper for N-player Tron.
//   clk, reset_n  : clock, asynchronous active-low reset
//   rnd (slave)   : round result handshake (round_over/draw/winner_id/ready)
//   clear_scores  : synchronous match restart from any state
//   match_ack     : acknowledges match end, starts a new match
//   scores        : packed scores, player i at [i*SCORE_W +: SCORE_W]
//   round_count   : rounds accepted this match (wraps)
//   match_over    : a player reached WIN_SCORE; match_winner valid with it
//   bad_id        : sticky, an out-of-range winner_id was accepted
// Optional macro TRON_SCORE_SATURATE_EN: scores and round_count saturate
// instead of wrapping.
module tron_score_tracker
    import tron_score_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 8,
    parameter int WIN_SCORE   = 5,
    parameter int ROUND_W     = 8,
    parameter int ID_W        = clog2_min1(NUM_PLAYERS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    tron_score_tracker_if.slave            rnd,
    input  logic                           clear_scores,
    input  logic                           match_ack,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [ROUND_W-1:0]             round_count,
    output logic                           match_over,
    output logic [ID_W-1:0]                match_winner,
    output logic                           bad_id
);

    if (!params_ok(NUM_PLAYERS, SCORE_W, WIN_SCORE)) begin : g_param_error
        $error("tron_score_tracker: illegal NUM_PLAYERS/SCORE_W/WIN_SCORE");
    end

    localparam logic [ID_W:0]    NP_L  = (ID_W + 1)'(NUM_PLAYERS);
    localparam logic [SCORE_W:0] WIN_L = (SCORE_W + 1)'(WIN_SCORE);

    state_t             state_reg, state_next;
    logic               ready_en_reg;
    logic [ROUND_W-1:0] round_count_reg;
    logic               match_over_reg;
    logic [ID_W-1:0]    match_winner_reg;
    logic               bad_id_reg;
    logic [ID_W-1:0]    last_id_reg;
    logic               last_win_reg;

    logic               accept;
    logic               id_valid;
    logic               score_win;
    logic               match_clear;
    logic               win_hit;
    logic [SCORE_W-1:0] sel_score;
    logic [SCORE_W-1:0] score_arr [NUM_PLAYERS];

    // ready_en_reg keeps round_ready low until the first clock after reset
    assign rnd.round_ready = (state_reg == IDLE) & ~clear_scores & ready_en_reg;
    assign accept          = rnd.round_over & rnd.round_ready;
    assign id_valid        = ({1'b0, rnd.winner_id} < NP_L);
    assign score_win       = accept & ~rnd.round_draw & id_valid;
    assign match_clear     = clear_scores | ((state_reg == MATCH_END) & match_ack);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            score_counter #(.SCORE_W(SCORE_W)) u_score (
                .clk     (clk),
                .reset_n (reset_n),
                .clear   (match_clear),
                .inc     (score_win & (rnd.winner_id == ID_W'(gi))),
                .value   (score_arr[gi])
            );
            assign scores[gi*SCORE_W +: SCORE_W] = score_arr[gi];
        end
    endgenerate

    // Score of the player credited by the round just accepted
    always_comb begin
        sel_score = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (last_id_reg == ID_W'(i))
                sel_score = score_arr[i];
        end
    end

    assign win_hit = (WIN_SCORE != 0) & last_win_reg & ({1'b0, sel_score} >= WIN_L);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (clear_scores) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:      if (accept) state_next = CHECK;
                CHECK:     state_next = win_hit ? MATCH_END : IDLE;
                MATCH_END: if (match_ack) state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_reg     <= 1'b0;
            round_count_reg  <= '0;
            match_over_reg   <= 1'b0;
            match_winner_reg <= '0;
            bad_id_reg       <= 1'b0;
            last_id_reg      <= '0;
            last_win_reg     <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;

            if (match_clear) begin
                round_count_reg  <= '0;
                match_over_reg   <= 1'b0;
                match_winner_reg <= '0;
            end else if (accept) begin
`ifdef TRON_SCORE_SATURATE_EN
                if (round_count_reg != '1)
                    round_count_reg <= round_count_reg + 1'b1;
`else
                round_count_reg <= round_count_reg + 1'b1;
`endif
            end else if ((state_reg == CHECK) && win_hit) begin
                match_over_reg   <= 1'b1;
                match_winner_reg <= last_id_reg;
            end

            if (clear_scores)
                bad_id_reg <= 1'b0;
            else if (accept & ~rnd.round_draw & ~id_valid)
                bad_id_reg <= 1'b1;

            // Draws and invalid ids never credit anyone, so CHECK cannot win
            if (accept) begin
                last_id_reg  <= rnd.winner_id;
                last_win_reg <= ~rnd.round_draw & id_valid;
            end
        end
    end

    assign round_count  = round_count_reg;
    assign match_over   = match_over_reg;
    assign match_winner = match_winner_reg;
    assign bad_id       = bad_id_reg;

endmodule

// File: tb/tb_tron_score_tracker.sv
// Bench for tron_score_tracker. Two instances:
//   dut_a : 3 players, 8-bit scores, first to 3 wins
//   dut_b : 2 players, 2-bit scores, 2-bit round counter, free-running
// A behavioural model per instance is advanced on every clock and compared
// with the outputs on every falling edge; directed scenarios add literal
// expectations.
module tb_tron_score_tracker;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    tron_score_tracker_if #(.ID_W(2)) a_if ();
    tron_score_tracker_if #(.ID_W(1)) b_if ();

    logic        a_clr = 0, a_ack = 0, b_clr = 0, b_ack = 0;
    logic [23:0] a_scores;
    logic [7:0]  a_rc;
    logic        a_over, a_bad;
    logic [1:0]  a_winner;
    logic [3:0]  b_scores;
    logic [1:0]  b_rc;
    logic        b_over, b_bad;
    logic [0:0]  b_winner;

    tron_score_tracker #(.NUM_PLAYERS(3), .SCORE_W(8), .WIN_SCORE(3), .ROUND_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .rnd(a_if.slave), .clear_scores(a_clr),
        .match_ack(a_ack), .scores(a_scores), .round_count(a_rc),
        .match_over(a_over), .match_winner(a_winner), .bad_id(a_bad)
    );

    tron_score_tracker #(.NUM_PLAYERS(2), .SCORE_W(2), .WIN_SCORE(0), .ROUND_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .rnd(b_if.slave), .clear_scores(b_clr),
        .match_ack(b_ack), .scores(b_scores), .round_count(b_rc),
        .match_over(b_over), .match_winner(b_winner), .bad_id(b_bad)
    );

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a round, 1 judging the last round, 2 match ended
    typedef struct packed {
        logic            alive;
        logic [1:0]      phase;
        logic [7:0][7:0] sc;
        logic [7:0]      rc;
        logic            over;
        logic [2:0]      mwin;
        logic            bad;
        logic [2:0]      last;
        logic            lastwin;
    } model_t;

    model_t ma, mb;

    function automatic logic [7:0] bump(input logic [7:0] v, input int w);
        logic [7:0] mx;
        mx = 8'((1 << w) - 1);
`ifdef TRON_SCORE_SATURATE_EN
        if (v == mx) return v;
`endif
        return (v + 8'd1) & mx;
    endfunction

    function automatic model_t step(input model_t m, input int np, input int sw,
                                    input int win, input int rw, input logic ro,
                                    input logic rd, input int id, input logic clr,
                                    input logic ack);
        model_t n;
        n = m;
        n.alive = 1'b1;
        if (clr) begin
            n.sc = '0; n.rc = '0; n.over = 0; n.mwin = 0; n.bad = 0; n.phase = 0;
        end else if (m.phase == 0) begin
            if (ro && m.alive) begin
                n.rc = bump(m.rc, rw);
                n.lastwin = 0;
                if (!rd) begin
                    if (id < np) begin
                        n.sc[3'(id)] = bump(m.sc[3'(id)], sw);
                        n.last = 3'(id);
                        n.lastwin = 1;
                    end else begin
                        n.bad = 1;
                    end
                end
                n.phase = 1;
            end
        end else if (m.phase == 1) begin
            if (win != 0 && m.lastwin && int'(m.sc[m.last]) >= win) begin
                n.over = 1; n.mwin = m.last; n.phase = 2;
            end else begin
                n.phase = 0;
            end
        end else if (ack) begin
            n.sc = '0; n.rc = '0; n.over = 0; n.mwin = 0; n.phase = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, 3, 8, 3, 8, a_if.round_over, a_if.round_draw,
                       int'(a_if.winner_id), a_clr, a_ack);
            mb <= step(mb, 2, 2, 0, 2, b_if.round_over, b_if.round_draw,
                       int'(b_if.winner_id), b_clr, b_ack);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("a_score%0d", i), 32'(a_scores[i*8 +: 8]), 32'(ma.sc[i]));
            chk("a_round_count", 32'(a_rc), 32'(ma.rc));
            chk("a_match_over", 32'(a_over), 32'(ma.over));
            chk("a_match_winner", 32'(a_winner), 32'(ma.mwin));
            chk("a_bad_id", 32'(a_bad), 32'(ma.bad));
            chk("a_round_ready", 32'(a_if.round_ready),
                32'(ma.alive && ma.phase == 0 && !a_clr));
            for (int i = 0; i < 2; i++)
                chk($sformatf("b_score%0d", i), 32'(b_scores[i*2 +: 2]), 32'(mb.sc[i][1:0]));
            chk("b_round_count", 32'(b_rc), 32'(mb.rc[1:0]));
            chk("b_match_over", 32'(b_over), 32'(mb.over));
            chk("b_round_ready", 32'(b_if.round_ready),
                32'(mb.alive && mb.phase == 0 && !b_clr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_send(input logic draw, input int id);
        int n;
        n = 0;
        while (a_if.round_ready !== 1'b1 && n < 50) begin
            cyc(1);
            n++;
        end
        chk("a_ready_wait", 32'(n < 50), 32'd1);
        a_if.round_over = 1; a_if.round_draw = draw; a_if.winner_id = 2'(id);
        cyc(1);
        a_if.round_over = 0; a_if.round_draw = 0;
        $display("round a: draw=%0d id=%0d scores=%h rc=%0d", draw, id, a_scores, a_rc);
    endtask

    task automatic b_send(input int id);
        int n;
        n = 0;
        while (b_if.round_ready !== 1'b1 && n < 50) begin
            cyc(1);
            n++;
        end
        chk("b_ready_wait", 32'(n < 50), 32'd1);
        b_if.round_over = 1; b_if.round_draw = 0; b_if.winner_id = 1'(id);
        cyc(1);
        b_if.round_over = 0;
        $display("round b: id=%0d scores=%h rc=%0d", id, b_scores, b_rc);
    endtask

    initial begin
        a_if.round_over = 0; a_if.round_draw = 0; a_if.winner_id = 0;
        b_if.round_over = 0; b_if.round_draw = 0; b_if.winner_id = 0;

        // Reset and release: ready only after the first clock out of reset
        #1;
        chk("rst_ready_low", 32'(a_if.round_ready), 32'd0);
        cyc(3);
        reset_n = 1;
        #1;
        chk("release_ready_low", 32'(a_if.round_ready), 32'd0);
        cyc(1);
        chk("release_ready_high", 32'(a_if.round_ready), 32'd1);

        // Reset in the middle of a match with scores {1,2}
        a_send(0, 1); a_send(0, 1); a_send(0, 0);
        cyc(1);
        chk("mid_scores_pre", 32'(a_scores), 32'h000201);
        reset_n = 0;
        #1;
        chk("mid_rst_scores", 32'(a_scores), 32'd0);
        chk("mid_rst_rc", 32'(a_rc), 32'd0);
        chk("mid_rst_over", 32'(a_over), 32'd0);
        chk("mid_rst_ready", 32'(a_if.round_ready), 32'd0);
        cyc(2);
        reset_n = 1;
        cyc(1);
        chk("mid_release_ready", 32'(a_if.round_ready), 32'd1);

        // Player 1 wins three rounds and takes the match
        a_send(0, 1); a_send(0, 1); a_send(0, 1);
        chk("win_score_p1", 32'(a_scores[15:8]), 32'd3);
        chk("win_over_not_yet", 32'(a_over), 32'd0);
        cyc(1);
        chk("win_over", 32'(a_over), 32'd1);
        chk("win_winner", 32'(a_winner), 32'd1);
        chk("win_rc", 32'(a_rc), 32'd3);
        chk("win_ready", 32'(a_if.round_ready), 32'd0);
        a_if.round_over = 1; a_if.winner_id = 0;
        cyc(1);
        a_if.round_over = 0;
        cyc(1);
        chk("end_ignored_p0", 32'(a_scores[7:0]), 32'd0);
        chk("end_ignored_rc", 32'(a_rc), 32'd3);

        // Acknowledge the match end
        a_ack = 1;
        cyc(1);
        a_ack = 0;
        chk("ack_scores", 32'(a_scores), 32'd0);
        chk("ack_rc", 32'(a_rc), 32'd0);
        chk("ack_over", 32'(a_over), 32'd0);
        chk("ack_ready", 32'(a_if.round_ready), 32'd1);

        // Draw, then an out-of-range id
        a_send(1, 2); a_send(0, 3);
        cyc(1);
        chk("draw_scores", 32'(a_scores), 32'd0);
        chk("draw_rc", 32'(a_rc), 32'd2);
        chk("draw_bad", 32'(a_bad), 32'd1);

        // clear_scores alongside round_over: nothing accepted, all cleared
        a_clr = 1; a_if.round_over = 1; a_if.winner_id = 0;
        cyc(1);
        a_clr = 0; a_if.round_over = 0;
        chk("clr_scores", 32'(a_scores), 32'd0);
        chk("clr_rc", 32'(a_rc), 32'd0);
        chk("clr_bad", 32'(a_bad), 32'd0);

        // round_over held three cycles: accepted in cycles 0 and 2 only
        a_if.round_over = 1; a_if.winner_id = 0;
        cyc(3);
        a_if.round_over = 0;
        cyc(1);
        chk("b2b_score", 32'(a_scores[7:0]), 32'd2);
        chk("b2b_rc", 32'(a_rc), 32'd2);

        // clear during CHECK on a winning round suppresses the match end
        a_send(0, 2); a_send(0, 2); a_send(0, 2);
        a_clr = 1;
        cyc(1);
        a_clr = 0;
        chk("clr_check_over", 32'(a_over), 32'd0);
        chk("clr_check_scores", 32'(a_scores), 32'd0);
        cyc(2);
        chk("clr_check_over2", 32'(a_over), 32'd0);

        // Free-running 2-bit score: five wins for player 0
        for (int i = 0; i < 5; i++) b_send(0);
        cyc(2);
`ifdef TRON_SCORE_SATURATE_EN
        chk("ovf_score", 32'(b_scores[1:0]), 32'd3);
        chk("ovf_rc", 32'(b_rc), 32'd3);
`else
        chk("ovf_score", 32'(b_scores[1:0]), 32'd1);
        chk("ovf_rc", 32'(b_rc), 32'd1);
`endif
        chk("ovf_over", 32'(b_over), 32'd0);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
